// File: rtl/vote_tally_sequencer.sv
// Drains stored votes from the vote_processor read port one request at a time and tallies yes/no.
// Define VOTE_TALLY_MAJORITY_EN to compile in the majority/tie reporting registers.
module vote_tally_sequencer #(
  parameter int unsigned MAX_VOTES      = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 15,
  localparam int unsigned W  = $clog2(MAX_VOTES + 1),
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         start_in,
  input  logic [W-1:0] num_votes_in,
  output logic         request_new_vote_out,
  input  logic         vote_in,
  input  logic         valid_vote_in,
  output logic [W-1:0] yes_count_out,
  output logic [W-1:0] no_count_out,
  output logic         busy_out,
  output logic         done_out,
  output logic         timeout_out,
  output logic         majority_out,
  output logic         tie_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [W-1:0]  MAX_W    = W'(MAX_VOTES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e        state_q, state_d;
  logic [W-1:0]  remaining_q, remaining_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [W-1:0]  yes_q, yes_d;
  logic [W-1:0]  no_q, no_d;
  logic          timeout_q, timeout_d;
  logic          req_q, req_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
`ifdef VOTE_TALLY_MAJORITY_EN
  logic          maj_q, maj_d;
  logic          tie_q, tie_d;
`endif

  // State and registered outputs
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      timer_q     <= '0;
      yes_q       <= '0;
      no_q        <= '0;
      timeout_q   <= 1'b0;
      req_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef VOTE_TALLY_MAJORITY_EN
      maj_q       <= 1'b0;
      tie_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      timer_q     <= timer_d;
      yes_q       <= yes_d;
      no_q        <= no_d;
      timeout_q   <= timeout_d;
      req_q       <= req_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef VOTE_TALLY_MAJORITY_EN
      maj_q       <= maj_d;
      tie_q       <= tie_d;
`endif
    end
  end

  // Next state and tally datapath; a valid in the timeout cycle is still counted
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    timer_d     = timer_q;
    yes_d       = yes_q;
    no_d        = no_q;
    timeout_d   = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          remaining_d = (num_votes_in > MAX_W) ? MAX_W : num_votes_in;
          yes_d       = '0;
          no_d        = '0;
          timeout_d   = 1'b0;
          state_d     = (remaining_d == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (valid_vote_in) begin
          if (vote_in) yes_d = yes_q + W'(1);
          else         no_d  = no_q + W'(1);
          remaining_d = remaining_q - W'(1);
          state_d     = (remaining_d == '0) ? S_DONE : S_ISSUE;
        end else if (timer_q == TIMER_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output register inputs, derived from the upcoming state
  always_comb begin
    req_d  = (state_d == S_ISSUE);
    busy_d = (state_d == S_ISSUE) || (state_d == S_WAIT);
    done_d = (state_d == S_DONE);
`ifdef VOTE_TALLY_MAJORITY_EN
    maj_d = maj_q;
    tie_d = tie_q;
    if (state_d == S_DONE) begin
      maj_d = (yes_d > no_d);
      tie_d = (yes_d == no_d);
    end else if (state_q == S_IDLE && start_in) begin
      maj_d = 1'b0;
      tie_d = 1'b0;
    end
`endif
  end

  assign request_new_vote_out = req_q;
  assign yes_count_out        = yes_q;
  assign no_count_out         = no_q;
  assign busy_out             = busy_q;
  assign done_out             = done_q;
  assign timeout_out          = timeout_q;
`ifdef VOTE_TALLY_MAJORITY_EN
  assign majority_out = maj_q;
  assign tie_out      = tie_q;
`else
  assign majority_out = 1'b0;
  assign tie_out      = 1'b0;
`endif

endmodule

// File: tb/tb_vote_tally_sequencer.sv
// Bench for vote_tally_sequencer: per-run event timeline model plus directed literal checks.
module tb_vote_tally_sequencer;

  localparam int MAXV = 8;
  localparam int TO   = 15;
  localparam int unsigned W = $clog2(MAXV + 1);
`ifdef VOTE_TALLY_MAJORITY_EN
  localparam bit MAJ_EN = 1'b1;
`else
  localparam bit MAJ_EN = 1'b0;
`endif

  logic         clk_in = 1'b0;
  logic         rst_in, start_in, vote_in, valid_vote_in;
  logic [W-1:0] num_votes_in;
  logic         request_new_vote_out, busy_out, done_out, timeout_out, majority_out, tie_out;
  logic [W-1:0] yes_count_out, no_count_out;

  always #5 clk_in = ~clk_in;

  vote_tally_sequencer #(.MAX_VOTES(MAXV), .TIMEOUT_CYCLES(TO)) dut (
    .clk_in               (clk_in),
    .rst_in               (rst_in),
    .start_in             (start_in),
    .num_votes_in         (num_votes_in),
    .request_new_vote_out (request_new_vote_out),
    .vote_in              (vote_in),
    .valid_vote_in        (valid_vote_in),
    .yes_count_out        (yes_count_out),
    .no_count_out         (no_count_out),
    .busy_out             (busy_out),
    .done_out             (done_out),
    .timeout_out          (timeout_out),
    .majority_out         (majority_out),
    .tie_out              (tie_out)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Expected outputs for the current cycle, and values held between runs
  logic e_req, e_busy, e_done, e_to, e_maj, e_tie;
  int   e_yes, e_no;
  int   h_yes, h_no;
  bit   h_to, h_maj, h_tie;

  // Per-run plan: vote bit and response latency (0 = never answered) for each request
  bit [15:0] p_vote;
  int        p_lat[16];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, got, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (chk_en) begin
      chk("request", 32'(request_new_vote_out), 32'(e_req));
      chk("busy",    32'(busy_out),             32'(e_busy));
      chk("done",    32'(done_out),             32'(e_done));
      chk("yes",     32'(yes_count_out),        32'(e_yes));
      chk("no",      32'(no_count_out),         32'(e_no));
      chk("timeout", 32'(timeout_out),          32'(e_to));
      chk("majority",32'(majority_out),         32'(e_maj));
      chk("tie",     32'(tie_out),              32'(e_tie));
    end
  end

  task automatic set_idle_exp();
    e_req = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    e_yes = h_yes; e_no = h_no; e_to = h_to; e_maj = h_maj; e_tie = h_tie;
  endtask

  // One run: start at t=0, read side answers request k after p_lat[k] cycles.
  // rst_sel: -1 no reset, -2 reset at a random in-run cycle, >=0 reset at that cycle.
  task automatic do_run(input int n, input int rst_sel, input bit noise,
                        output int obs_done, output int obs_reqs);
    int r[16];
    int v[16];
    int neff, tcur, tdone, nv, tend, rst_at, fyes, fno, vk, cy, cn;
    bit stall, vhit, issue_t, post_rst;
    neff = (n > MAXV) ? MAXV : n;
    for (int k = 0; k < 16; k++) begin r[k] = -1; v[k] = -1; end
    tcur = 1; stall = 1'b0; nv = neff;
    for (int k = 0; k < neff; k++) begin
      r[k] = tcur;
      if (p_lat[k] == 0) begin stall = 1'b1; nv = k; break; end
      v[k] = tcur + p_lat[k];
      tcur = v[k] + 1;
    end
    tdone = stall ? tcur + TO + 1 : tcur;
    fyes = 0; fno = 0;
    for (int k = 0; k < nv; k++) begin
      if (p_vote[k]) fyes++; else fno++;
    end
    if (rst_sel == -2) rst_at = (tdone > 1) ? int'($urandom_range(1, tdone - 1)) : -1;
    else               rst_at = rst_sel;
    tend = (rst_at >= 0) ? rst_at + 3 : tdone + int'($urandom_range(0, 3));
    obs_done = -1; obs_reqs = 0;
    for (int t = 0; t <= tend; t++) begin
      vhit = 1'b0; vk = 0; issue_t = 1'b0;
      for (int k = 0; k < nv; k++) if (v[k] == t) begin vhit = 1'b1; vk = k; end
      for (int k = 0; k < 16; k++) if (r[k] == t) issue_t = 1'b1;
      post_rst = (rst_at >= 0) && (t > rst_at);
      rst_in   = (t == rst_at);
      start_in = (t == 0) || (noise && rst_at < 0 && t >= 1 && t <= tdone && $urandom_range(0, 3) == 0);
      num_votes_in = (t == 0) ? W'(n) : W'($urandom_range(0, 15));
      valid_vote_in = vhit || (noise && (t == 0 || issue_t || t >= tdone || post_rst) &&
                               $urandom_range(0, 1) == 1);
      vote_in = vhit ? p_vote[vk] : 1'($urandom_range(0, 1));
      if (post_rst) begin
        e_req = 0; e_busy = 0; e_done = 0; e_yes = 0; e_no = 0; e_to = 0; e_maj = 0; e_tie = 0;
      end else if (t == 0) begin
        set_idle_exp();
      end else begin
        cy = 0; cn = 0;
        for (int k = 0; k < nv; k++) if (v[k] < t) begin
          if (p_vote[k]) cy++; else cn++;
        end
        e_req  = issue_t;
        e_busy = (t < tdone);
        e_done = (t == tdone);
        e_yes  = cy;
        e_no   = cn;
        e_to   = (t >= tdone) && stall;
        e_maj  = (t >= tdone) && MAJ_EN && (fyes > fno);
        e_tie  = (t >= tdone) && MAJ_EN && (fyes == fno);
      end
      if (done_out && obs_done < 0) obs_done = t;
      if (request_new_vote_out) obs_reqs++;
      @(posedge clk_in); #1;
    end
    if (rst_at >= 0) begin
      h_yes = 0; h_no = 0; h_to = 0; h_maj = 0; h_tie = 0;
    end else begin
      h_yes = fyes; h_no = fno; h_to = stall;
      h_maj = MAJ_EN && (fyes > fno);
      h_tie = MAJ_EN && (fyes == fno);
    end
    rst_in = 1'b0; start_in = 1'b0; valid_vote_in = 1'b0; vote_in = 1'b0;
    set_idle_exp();
  endtask

  task automatic plan_fixed(input int lat, input bit [15:0] votes);
    p_vote = votes;
    for (int k = 0; k < 16; k++) p_lat[k] = lat;
  endtask

  initial begin
    int od, orq, sel;
    rst_in = 1'b1; start_in = 1'b0; vote_in = 1'b0; valid_vote_in = 1'b0; num_votes_in = '0;
    h_yes = 0; h_no = 0; h_to = 0; h_maj = 0; h_tie = 0;
    @(posedge clk_in); #1;
    start_in = 1'b1; valid_vote_in = 1'b1; vote_in = 1'b1; num_votes_in = W'(3);
    set_idle_exp();
    chk_en = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0; start_in = 1'b0; valid_vote_in = 1'b0; vote_in = 1'b0;
    @(posedge clk_in); #1;

    // Five votes 1,0,1,1,0 on the nominal 2-cycle read pipe
    plan_fixed(2, 16'b01101);
    do_run(5, -1, 1'b0, od, orq);
    chk("t1_done_cycle", 32'(od), 32'd16);
    chk("t1_requests",   32'(orq), 32'd5);
    chk("t1_yes",        32'(yes_count_out), 32'd3);
    chk("t1_no",         32'(no_count_out), 32'd2);
    chk("t1_timeout",    32'(timeout_out), 32'd0);
    chk("t1_majority",   32'(majority_out), 32'(MAJ_EN));
    chk("t1_tie",        32'(tie_out), 32'd0);

    // Empty run
    do_run(0, -1, 1'b0, od, orq);
    chk("t2_done_cycle", 32'(od), 32'd1);
    chk("t2_requests",   32'(orq), 32'd0);
    chk("t2_yes",        32'(yes_count_out), 32'd0);
    chk("t2_tie",        32'(tie_out), 32'(MAJ_EN));

    // Read side stalls on the first request
    plan_fixed(0, 16'h0);
    do_run(3, -1, 1'b0, od, orq);
    chk("t3_done_cycle", 32'(od), 32'd17);
    chk("t3_requests",   32'(orq), 32'd1);
    chk("t3_timeout",    32'(timeout_out), 32'd1);
    chk("t3_yes",        32'(yes_count_out), 32'd0);
    chk("t3_busy_after", 32'(busy_out), 32'd0);

    // Request count clamped to MAX_VOTES
    plan_fixed(2, 16'hFFFF);
    do_run(12, -1, 1'b0, od, orq);
    chk("t4_requests",   32'(orq), 32'd8);
    chk("t4_yes",        32'(yes_count_out), 32'd8);
    chk("t4_no",         32'(no_count_out), 32'd0);
    chk("t4_done_cycle", 32'(od), 32'd25);

    // Starts while busy and spurious valids outside WAIT are ignored
    plan_fixed(2, 16'b1001);
    do_run(4, -1, 1'b1, od, orq);
    chk("t5_requests",   32'(orq), 32'd4);
    chk("t5_done_cycle", 32'(od), 32'd13);
    chk("t5_yes",        32'(yes_count_out), 32'd2);

    // Reset in WAIT with the in-flight valid arriving just after it
    plan_fixed(2, 16'hF);
    do_run(4, 2, 1'b0, od, orq);
    chk("t6_done_seen",  32'(od), 32'hFFFF_FFFF);
    chk("t6_yes",        32'(yes_count_out), 32'd0);
    plan_fixed(2, 16'b11);
    do_run(2, -1, 1'b0, od, orq);
    chk("t6b_done_cycle",32'(od), 32'd7);
    chk("t6b_yes",       32'(yes_count_out), 32'd2);

    // Valid on the last WAIT cycle before timeout is counted
    plan_fixed(TO, 16'b10);
    do_run(2, -1, 1'b0, od, orq);
    chk("t7_done_cycle", 32'(od), 32'd33);
    chk("t7_timeout",    32'(timeout_out), 32'd0);
    chk("t7_no",         32'(no_count_out), 32'd1);

    // Randomized runs
    for (int i = 0; i < 150; i++) begin
      p_vote = 16'($urandom);
      for (int k = 0; k < 16; k++) begin
        sel = int'($urandom_range(0, 19));
        p_lat[k] = (sel == 0) ? 0 : (sel < 5) ? int'($urandom_range(1, TO)) : 2;
      end
      sel = ($urandom_range(0, 9) == 0) ? -2 : -1;
      do_run(int'($urandom_range(0, 12)), sel, 1'($urandom_range(0, 1)), od, orq);
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk_in); #1;
      end
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vote_tally_sequencer.md
Name: vote_tally_sequencer

Overview:
- Controller that drains stored votes from the vote_processor read port, one request at a time, and tallies yes/no counts.
- Sits between vote_processor (read side) and the result/reporting logic.
- Issues single-cycle `request_new_vote` pulses and waits for `valid_vote_out` from the 2-cycle BRAM read pipe.
- Guards against a stalled read port with a timeout and reports completion.

Parameters:
- MAX_VOTES, 10000, maximum votes tallied per run; sets counter widths (W = $clog2(MAX_VOTES+1)).
- TIMEOUT_CYCLES, 15, cycles in WAIT without `valid_vote_in` before the run aborts.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset, synchronous, active-high.
- start_in  input  1  begin a run; sampled only in IDLE.
- num_votes_in  input  W  votes to read this run; sampled with `start_in`.
- request_new_vote_out  output  1  one-cycle read request to vote_processor.
- vote_in  input  1  vote bit from vote_processor, qualified by `valid_vote_in`.
- valid_vote_in  input  1  vote_in valid.
- yes_count_out  output  W  votes equal to 1 this run.
- no_count_out  output  W  votes equal to 0 this run.
- busy_out  output  1  high in ISSUE and WAIT.
- done_out  output  1  one-cycle pulse at end of run.
- timeout_out  output  1  sticky; last run aborted on timeout.
- majority_out  output  1  see Optional Feature.
- tie_out  output  1  see Optional Feature.

Behaviour:
- Clock and reset: one clock, `clk_in`. `rst_in` is synchronous and active-high.
- Reset values:
  - State = IDLE.
  - All outputs 0; counts 0.
  - Remaining counter 0; timer 0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - `start_in`=1 latches remaining = min(`num_votes_in`, MAX_VOTES).
  - The same start clears yes/no counts, `timeout_out`, `majority_out` and `tie_out`.
  - remaining=0 → DONE; else → ISSUE.
  - `valid_vote_in` is ignored.
- ISSUE:
  - `request_new_vote_out`=1 for exactly this cycle.
  - Timer cleared.
  - → WAIT unconditionally.
- WAIT:
  - On `valid_vote_in`=1: increment yes (`vote_in`=1) or no (`vote_in`=0) and decrement remaining.
  - If the decremented value is 0 → DONE, else → ISSUE.
  - Otherwise the timer increments. Timer = TIMEOUT_CYCLES-1 with no valid → set `timeout_out`, → DONE; counts keep partial values.
  - `valid_vote_in` and timeout in the same cycle: the valid wins, the vote is counted, no timeout.
- DONE:
  - `done_out`=1 for this single cycle.
  - Optional-feature outputs are updated here.
  - → IDLE.
- Outstanding requests: at most one at a time. No new request is issued until the prior valid is received or the timeout fires.
- Spurious `valid_vote_in` in IDLE, ISSUE or DONE is ignored and does not change counts.
- `start_in` while not in IDLE is ignored; it is not queued.
- Latency with the 2-cycle read pipe:
  - Start accepted at cycle 0.
  - Request k (k=0..N-1) at cycle 1+3k; its valid arrives at 3+3k.
  - `done_out` at cycle 3N+1.
  - N=0 gives `done_out` at cycle 1.
- Widths: counts are W bits and never wrap, since yes+no ≤ remaining ≤ MAX_VOTES.
- Outputs after the run: `yes_count_out`, `no_count_out` and `timeout_out` hold their values after DONE until the next accepted start or reset.
- Reset mid-run: returns to IDLE next cycle with all outputs 0. Any in-flight valid afterwards is ignored.

Optional Feature:
- Macro: VOTE_TALLY_MAJORITY_EN.
- Defined:
  - In DONE, `majority_out` = (yes_count > no_count) and `tie_out` = (yes_count == no_count), both using the final counts including that cycle's last vote.
  - Held until the next accepted start or reset.
  - A timed-out run also reports on its partial counts.
- Undefined: comparator logic is not compiled; `majority_out` and `tie_out` are tied to 0.

Test Plan:
- N=5, vote bits 1,0,1,1,0 returned 2 cycles after each request → yes=3, no=2, 5 request pulses at cycles 1,4,7,10,13, `done_out` at cycle 16, timeout=0. With macro: majority=1, tie=0.
- N=0 start → no request pulse, `done_out` at cycle 1, counts 0. With macro: tie=1.
- N=3, read side never returns valid → single request at cycle 1, `timeout_out`=1, `done_out` after TIMEOUT_CYCLES in WAIT, counts 0, `busy_out` low afterwards.
- With MAX_VOTES=8, `num_votes_in`=12, all votes 1 → exactly 8 requests, yes=8, no=0.
- Start mid-run (`start_in` pulsed in WAIT), plus spurious `valid_vote_in` in IDLE → both ignored, tallies unaffected, next start accepted only after `done_out`.
- `rst_in` asserted during WAIT of a N=4 run, with a valid arriving the cycle after reset → all outputs 0, state IDLE, that valid not counted. A fresh N=2 run then completes correctly.
